// File: rtl/l2_cacheline_adapter_if.sv
// Bus bundle between the L2 controller / burst memory and the cacheline adapter.
// The slave modport is the adapter's view. The master modport is the view of
// the environment that drives the adapter: the L2 controller and the memory.
interface l2_cacheline_adapter_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
);
  // L2 side
  logic [31:0]        line_address_i;
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  // Burst memory side
  logic [31:0]        burst_address_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic               burst_read_o;
  logic               burst_write_o;
  logic               burst_resp_i;

  modport slave (
    input  line_address_i, line_i, read_i, write_i, burst_i, burst_resp_i,
    output line_o, resp_o, burst_address_o, burst_o, burst_read_o, burst_write_o
  );

  modport master (
    output line_address_i, line_i, read_i, write_i, burst_i, burst_resp_i,
    input  line_o, resp_o, burst_address_o, burst_o, burst_read_o, burst_write_o
  );
endinterface

// File: rtl/l2_cacheline_adapter.sv
// Converts one L2 cacheline fill or writeback into a num_beats burst on a
// narrow memory interface. It returns a single-cycle resp_o when the burst is done.
module l2_cacheline_adapter #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_offset = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_cacheline_adapter_if.slave bus
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  // Shared beat buffer: holds writeback data in WRITE and collects fill beats in READ.
  logic [s_line-1:0]   buf_q, buf_d;
  // Published fill line. It changes only when a read completes.
  logic [s_line-1:0]   line_q, line_d;

  // Next-state logic for the FSM, beat counter and data buffers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (bus.write_i || bus.read_i) begin
          addr_d = {bus.line_address_i[31:s_offset], {s_offset{1'b0}}};
          cnt_d  = '0;
        end
        // A writeback wins over a fill when both are requested.
        if (bus.write_i) begin
          buf_d   = bus.line_i;
          state_d = StWrite;
        end else if (bus.read_i) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (bus.burst_resp_i) begin
          buf_d[cnt_q*s_burst +: s_burst] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            line_d  = buf_d;
            state_d = StDone;
          end
        end
      end
      StWrite: begin
        if (bus.burst_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    bus.burst_read_o    = (state_q == StRead);
    bus.burst_write_o   = (state_q == StWrite);
    bus.resp_o          = (state_q == StDone);
    bus.burst_address_o = addr_q;
    bus.line_o          = line_q;
    bus.burst_o         = '0;
    if (state_q == StWrite) begin
      bus.burst_o = buf_q[cnt_q*s_burst +: s_burst];
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Directed testbench for l2_cacheline_adapter. Most checking is driven from a
// per-cycle vector table. Reset abort and back-to-back traffic are checked
// with hand-written sequences.
module tb_l2_cacheline_adapter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  l2_cacheline_adapter_if #(.s_line(256), .s_burst(64)) bus ();

  l2_cacheline_adapter #(.s_line(256), .s_burst(64), .s_offset(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [63:0]  bi;
    logic         br;
    logic         e_resp;
    logic         e_rd;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [63:0]  e_bo;
    logic [255:0] e_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] line, input logic [63:0] bi, input logic br,
                              input logic e_resp, input logic e_rd, input logic e_wr,
                              input logic [31:0] e_addr, input logic [63:0] e_bo,
                              input logic [255:0] e_lo);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.line = line; v.bi = bi; v.br = br;
    v.e_resp = e_resp; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_bo = e_bo; v.e_lo = e_lo;
    vecs.push_back(v);
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait transaction with the request dropped for one cycle after resp_o.
  // mem supplies the fill beats; ln is the writeback line.
  task automatic txn(input string nm, input logic wr, input logic [31:0] a,
                     input logic [255:0] ln, input logic [255:0] mem,
                     input logic [255:0] e_lo);
    logic [31:0] e_addr;
    e_addr = {a[31:5], 5'b0};
    bus.write_i = wr;
    bus.read_i = !wr;
    bus.line_address_i = a;
    bus.line_i = ln;
    bus.burst_resp_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = mem[64*k +: 64];
      bus.burst_resp_i = 1'b1;
      chk_bit($sformatf("%s beat%0d burst_read_o", nm, k), bus.burst_read_o, !wr);
      chk_bit($sformatf("%s beat%0d burst_write_o", nm, k), bus.burst_write_o, wr);
      chk_w($sformatf("%s beat%0d burst_address_o", nm, k), 256'(bus.burst_address_o),
            256'(e_addr));
      if (wr) begin
        chk_w($sformatf("%s beat%0d burst_o", nm, k), 256'(bus.burst_o), 256'(ln[64*k +: 64]));
      end
      tick();
    end
    bus.burst_resp_i = 1'b0;
    chk_bit({nm, " done resp_o"}, bus.resp_o, 1'b1);
    chk_w({nm, " done line_o"}, bus.line_o, e_lo);
    chk_bit({nm, " done burst_read_o"}, bus.burst_read_o, 1'b0);
    chk_bit({nm, " done burst_write_o"}, bus.burst_write_o, 1'b0);
    tick();
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    chk_bit({nm, " post resp_o"}, bus.resp_o, 1'b0);
    tick();
    chk_bit({nm, " gap resp_o"}, bus.resp_o, 1'b0);
    chk_bit({nm, " gap burst_read_o"}, bus.burst_read_o, 1'b0);
    chk_bit({nm, " gap burst_write_o"}, bus.burst_write_o, 1'b0);
  endtask

  logic [63:0]  b1, b2, b3, b4, wa, wb, wc, wd, e0, e1, e2, e3;
  logic [255:0] l1, w, w2, l3, f, x, y;

  initial begin
    checks = 0;
    errors = 0;
    b1 = {16{4'h1}}; b2 = {16{4'h2}}; b3 = {16{4'h3}}; b4 = {16{4'h4}};
    wa = {16{4'hA}}; wb = {16{4'hB}}; wc = {16{4'hC}}; wd = {16{4'hD}};
    e0 = 64'h0123_4567_89AB_CDEF; e1 = 64'hFEDC_BA98_7654_3210;
    e2 = 64'h0F0F_0F0F_F0F0_F0F0; e3 = 64'h8000_0000_0000_0001;
    l1 = {b4, b3, b2, b1};
    w  = {wd, wc, wb, wa};
    w2 = ~w;
    l3 = {e3, e2, e1, e0};
    f  = {64'hF4F4_0000_0000_0004, 64'hF3F3_0000_0000_0003,
          64'hF2F2_0000_0000_0002, 64'hF1F1_0000_0000_0001};
    x  = {64'h0DD0_0DD0_0DD0_0DD3, 64'h0DD0_0DD0_0DD0_0DD2,
          64'h0DD0_0DD0_0DD0_0DD1, 64'h0DD0_0DD0_0DD0_0DD0};
    y  = {64'h5A5A_5A5A_0000_0003, 64'h5A5A_5A5A_0000_0002,
          64'h5A5A_5A5A_0000_0001, 64'h5A5A_5A5A_0000_0000};

    // Fill of 0x1234 at zero wait; the burst_resp_i in the idle cycle must be ignored.
    add(1, 0, 32'h0000_1234, '0, 64'hDEAD, 1,  0, 0, 0, 32'h0, 64'h0, '0);
    add(1, 0, 32'h0000_1234, '0, b1, 1,        0, 1, 0, 32'h0000_1220, 64'h0, '0);
    add(1, 0, 32'h0000_1234, '0, b2, 1,        0, 1, 0, 32'h0000_1220, 64'h0, '0);
    add(1, 0, 32'h0000_1234, '0, b3, 1,        0, 1, 0, 32'h0000_1220, 64'h0, '0);
    add(1, 0, 32'h0000_1234, '0, b4, 1,        0, 1, 0, 32'h0000_1220, 64'h0, '0);
    add(1, 0, 32'h0000_1234, '0, 64'h0, 0,     1, 0, 0, 32'h0000_1220, 64'h0, l1);
    add(0, 0, 32'h0000_1234, '0, 64'h0, 0,     0, 0, 0, 32'h0000_1220, 64'h0, l1);
    // Writeback to 0x8000_0040; address and line inputs are scrambled mid-burst.
    add(0, 1, 32'h8000_0040, w, 64'h0, 0,      0, 0, 0, 32'h0000_1220, 64'h0, l1);
    add(0, 1, 32'hFFFF_FFFF, ~w, 64'h0, 1,     0, 0, 1, 32'h8000_0040, wa, l1);
    add(0, 1, 32'hFFFF_FFFF, ~w, 64'h0, 1,     0, 0, 1, 32'h8000_0040, wb, l1);
    add(0, 1, 32'hFFFF_FFFF, ~w, 64'h0, 1,     0, 0, 1, 32'h8000_0040, wc, l1);
    add(0, 1, 32'hFFFF_FFFF, ~w, 64'h0, 1,     0, 0, 1, 32'h8000_0040, wd, l1);
    add(0, 1, 32'hFFFF_FFFF, ~w, 64'h0, 0,     1, 0, 0, 32'h8000_0040, 64'h0, l1);
    add(0, 0, 32'h0, '0, 64'h0, 0,             0, 0, 0, 32'h8000_0040, 64'h0, l1);
    // Fill with a 3-cycle stall between beats 1 and 2; resp_o lands in cycle 8.
    add(1, 0, 32'h0000_201F, '0, 64'h0, 0,     0, 0, 0, 32'h8000_0040, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, e0, 1,        0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, e1, 1,        0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, 64'hBAD, 0,   0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, 64'hBAD, 0,   0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, 64'hBAD, 0,   0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, e2, 1,        0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, e3, 1,        0, 1, 0, 32'h0000_2000, 64'h0, l1);
    add(1, 0, 32'h0000_201F, '0, 64'h0, 0,     1, 0, 0, 32'h0000_2000, 64'h0, l3);
    add(0, 0, 32'h0, '0, 64'h0, 0,             0, 0, 0, 32'h0000_2000, 64'h0, l3);
    // Read and write both high: the writeback wins and no fill burst is issued.
    add(1, 1, 32'h0000_0100, w2, 64'h0, 0,     0, 0, 0, 32'h0000_2000, 64'h0, l3);
    add(1, 1, 32'h0000_0100, w2, 64'h0, 1,     0, 0, 1, 32'h0000_0100, ~wa, l3);
    add(1, 1, 32'h0000_0100, w2, 64'h0, 1,     0, 0, 1, 32'h0000_0100, ~wb, l3);
    add(1, 1, 32'h0000_0100, w2, 64'h0, 1,     0, 0, 1, 32'h0000_0100, ~wc, l3);
    add(1, 1, 32'h0000_0100, w2, 64'h0, 1,     0, 0, 1, 32'h0000_0100, ~wd, l3);
    add(1, 1, 32'h0000_0100, w2, 64'h0, 0,     1, 0, 0, 32'h0000_0100, 64'h0, l3);
    add(0, 0, 32'h0, '0, 64'h0, 0,             0, 0, 0, 32'h0000_0100, 64'h0, l3);

    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.line_address_i = '0;
    bus.line_i = '0;
    bus.burst_i = '0;
    bus.burst_resp_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset resp_o", bus.resp_o, 1'b0);
    chk_bit("reset burst_read_o", bus.burst_read_o, 1'b0);
    chk_bit("reset burst_write_o", bus.burst_write_o, 1'b0);
    chk_w("reset burst_address_o", 256'(bus.burst_address_o), 256'(32'h0));
    chk_w("reset burst_o", 256'(bus.burst_o), 256'(64'h0));
    chk_w("reset line_o", bus.line_o, '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.read_i = vecs[i].rd;
      bus.write_i = vecs[i].wr;
      bus.line_address_i = vecs[i].addr;
      bus.line_i = vecs[i].line;
      bus.burst_i = vecs[i].bi;
      bus.burst_resp_i = vecs[i].br;
      chk_bit($sformatf("vec%0d resp_o", i), bus.resp_o, vecs[i].e_resp);
      chk_bit($sformatf("vec%0d burst_read_o", i), bus.burst_read_o, vecs[i].e_rd);
      chk_bit($sformatf("vec%0d burst_write_o", i), bus.burst_write_o, vecs[i].e_wr);
      chk_w($sformatf("vec%0d burst_address_o", i), 256'(bus.burst_address_o),
            256'(vecs[i].e_addr));
      chk_w($sformatf("vec%0d burst_o", i), 256'(bus.burst_o), 256'(vecs[i].e_bo));
      chk_w($sformatf("vec%0d line_o", i), bus.line_o, vecs[i].e_lo);
      tick();
    end

    // Reset asserted during beat 2 of a fill aborts it at once.
    bus.read_i = 1'b1;
    bus.line_address_i = 32'h0000_3004;
    bus.burst_resp_i = 1'b0;
    tick();
    bus.burst_i = 64'h1;
    bus.burst_resp_i = 1'b1;
    tick();
    bus.burst_i = 64'h2;
    tick();
    bus.burst_i = 64'h3;
    rst = 1'b0;
    #1;
    chk_bit("abort resp_o", bus.resp_o, 1'b0);
    chk_bit("abort burst_read_o", bus.burst_read_o, 1'b0);
    chk_bit("abort burst_write_o", bus.burst_write_o, 1'b0);
    chk_w("abort burst_address_o", 256'(bus.burst_address_o), 256'(32'h0));
    chk_w("abort burst_o", 256'(bus.burst_o), 256'(64'h0));
    chk_w("abort line_o", bus.line_o, '0);
    bus.read_i = 1'b0;
    bus.burst_resp_i = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit($sformatf("post-abort%0d resp_o", i), bus.resp_o, 1'b0);
      chk_bit($sformatf("post-abort%0d burst_read_o", i), bus.burst_read_o, 1'b0);
    end
    txn("fresh read", 1'b0, 32'h0000_3000, '0, f, f);

    // Dirty eviction: writeback then fill, one idle cycle between them.
    txn("evict write", 1'b1, 32'h8000_0040, x, '0, f);
    txn("evict fill", 1'b0, 32'h0000_5008, '0, y, y);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
